// File: rtl/io_pkg.sv
// Shared defaults and types for the processor output-port path.
package io_pkg;

    localparam int OUT_WORD_W     = 16;
    localparam int OUT_FIFO_DEPTH = 4;

    typedef logic [OUT_WORD_W-1:0] out_word_t;

    // The occupancy counter must represent 0..depth inclusive, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH register array: synchronous write port, combinational read port.
module fifo_mem_2p
    import io_pkg::*;
#(
    parameter int WIDTH = OUT_WORD_W,
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents need no reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// First-word-fall-through buffer behind the processor output register.
// Optional duplicate-push filter enabled by defining OUT_FIFO_DUP_FILTER_EN.
module out_port_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = OUT_WORD_W,
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic [WIDTH-1:0] mem_rdata_s;
    logic             push_try_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;
    logic             full_s;
    logic             valid_s;

    // Flags come only from the registered count, so inputs never reach the read side.
    assign full_s   = (count_r == CNT_FULL);
    assign valid_s  = (count_r != {CNT_W{1'b0}});
    assign full     = full_s;
    assign rd_valid = valid_s;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign rd_data  = valid_s ? mem_rdata_s : {WIDTH{1'b0}};

`ifdef OUT_FIFO_DUP_FILTER_EN
    logic [WIDTH-1:0] last_word_r;
    logic             last_vld_r;

    // A repeat of the last accepted word is discarded before it can count as a push.
    always_comb begin
        push_try_s = wr_en;
        if (last_vld_r && (wr_data == last_word_r)) begin
            push_try_s = 1'b0;
        end else begin
            push_try_s = wr_en;
        end
    end

    // Remember the most recently accepted word.
    always_ff @(posedge CLK) begin
        if (reset) begin
            last_word_r <= {WIDTH{1'b0}};
            last_vld_r  <= 1'b0;
        end else if (push_ok_s) begin
            last_word_r <= wr_data;
            last_vld_r  <= 1'b1;
        end
    end
`else
    assign push_try_s = wr_en;
`endif

    // A pop frees a slot on the same edge, so a push into a full FIFO can still land.
    always_comb begin
        pop_s     = valid_s & rd_ready;
        push_ok_s = push_try_s & (~full_s | pop_s);
        drop_s    = push_try_s & full_s & ~pop_s;
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wptr_r     <= {PTR_W{1'b0}};
            rptr_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (push_ok_s & ~reset),
        .waddr (wptr_r),
        .wdata (wr_data),
        .raddr (rptr_r),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed self-checking bench for out_port_fifo (define OUT_FIFO_DUP_FILTER_EN for the filter case).
module tb_out_port_fifo;

    logic        CLK;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [2:0]  count;
    logic        overflow;

    int checks;
    int errors;

    out_port_fifo dut (
        .CLK      (CLK),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 16'h0000;
        rd_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state, then single push latency
        check_eq("rst_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_count", {29'd0, count}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_data", {16'd0, rd_data}, 32'd0);
        push(16'h1234);
        check_eq("p1_valid", {31'd0, rd_valid}, 32'd1);
        check_eq("p1_data", {16'd0, rd_data}, 32'h1234);
        check_eq("p1_count", {29'd0, count}, 32'd1);

        // Fill, overflow, drain
        do_reset();
        for (int i = 1; i <= 4; i++) push(16'(i));
        check_eq("fill_full", {31'd0, full}, 32'd1);
        check_eq("fill_count", {29'd0, count}, 32'd4);
        check_eq("fill_ovf0", {31'd0, overflow}, 32'd0);
        push(16'h0005);
        check_eq("drop_ovf", {31'd0, overflow}, 32'd1);
        check_eq("drop_count", {29'd0, count}, 32'd4);
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("drain_valid", {31'd0, rd_valid}, 32'd1);
            check_eq("drain_data", {16'd0, rd_data}, 32'(i));
            step();
        end
        rd_ready = 1'b0;
        check_eq("drain_empty", {31'd0, rd_valid}, 32'd0);
        check_eq("drain_zero", {16'd0, rd_data}, 32'd0);
        check_eq("drain_ovf", {31'd0, overflow}, 32'd1);

        // Push while full with simultaneous pop
        do_reset();
        for (int i = 1; i <= 4; i++) push(16'(i));
        wr_en    = 1'b1;
        wr_data  = 16'h00AA;
        rd_ready = 1'b1;
        step();
        wr_en    = 1'b0;
        check_eq("pp_count", {29'd0, count}, 32'd4);
        check_eq("pp_full", {31'd0, full}, 32'd1);
        check_eq("pp_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            check_eq("pp_drain", {16'd0, rd_data}, 32'(i));
            step();
        end
        check_eq("pp_last", {16'd0, rd_data}, 32'h00AA);
        step();
        rd_ready = 1'b0;
        check_eq("pp_empty", {31'd0, rd_valid}, 32'd0);

        // Stall stability
        do_reset();
        push(16'h0011);
        push(16'h0022);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_data", {16'd0, rd_data}, 32'h0011);
        end
        pop_one();
        check_eq("stall_next", {16'd0, rd_data}, 32'h0022);
        check_eq("stall_count", {29'd0, count}, 32'd1);

        // Streaming through the pointer wrap
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0100 + 16'(i);
            step();
            check_eq("strm_data", {16'd0, rd_data}, 32'h0100 + 32'(i));
            check_eq("strm_count", {29'd0, count}, 32'd1);
        end
        wr_en = 1'b0;
        step();
        rd_ready = 1'b0;
        check_eq("strm_empty", {31'd0, rd_valid}, 32'd0);
        check_eq("strm_ovf", {31'd0, overflow}, 32'd0);

        // Reset beats a concurrent push
        do_reset();
        for (int i = 1; i <= 5; i++) push(16'(i));
        pop_one();
        check_eq("mid_count3", {29'd0, count}, 32'd3);
        check_eq("mid_ovf1", {31'd0, overflow}, 32'd1);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h0BAD;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        check_eq("mid_count", {29'd0, count}, 32'd0);
        check_eq("mid_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("mid_ovf", {31'd0, overflow}, 32'd0);

`ifdef OUT_FIFO_DUP_FILTER_EN
        // Consecutive duplicates are filtered
        do_reset();
        push(16'h0007);
        push(16'h0007);
        push(16'h0008);
        push(16'h0007);
        check_eq("dup_count", {29'd0, count}, 32'd3);
        check_eq("dup_ovf", {31'd0, overflow}, 32'd0);
        rd_ready = 1'b1;
        check_eq("dup_d0", {16'd0, rd_data}, 32'h0007);
        step();
        check_eq("dup_d1", {16'd0, rd_data}, 32'h0008);
        step();
        check_eq("dup_d2", {16'd0, rd_data}, 32'h0007);
        step();
        rd_ready = 1'b0;
        check_eq("dup_empty", {31'd0, rd_valid}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
